instr_cache: RTL and testbench
==============================

// Module: instr_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache between the CPU fetch port and the
//  slow block-oriented instruction memory. Takes PC, returns the 32-bit INSTRUCTION
//  and drives BUSYWAIT into the CPU's IMEMBUSYWAIT input, so the PC holds on a miss.
//  On a miss it fetches one 128-bit block (4 instructions) and then serves the hit.
// PARAMETERS
//  INDEX_BITS  3   index width; number of blocks = 2**INDEX_BITS (8)
//  TAG_BITS    3   tag width; cached byte-address space = 2**(TAG_BITS+INDEX_BITS+4) (1 KiB)
//  CNT_BITS    16  width of the hit and miss performance counters
// PORTS
//  CLK           in   1    clock; all state updates on the rising edge
//  RESET         in   1    synchronous, active-high reset
//  PC            in   32   fetch byte address from the CPU
//  INSTRUCTION   out  32   fetched instruction; valid only while BUSYWAIT=0
//  BUSYWAIT      out  1    stall request to the CPU (its IMEMBUSYWAIT input)
//  MEM_READ      out  1    block read request to the instruction memory
//  MEM_ADDRESS   out  6    block address {tag,index} = PC[9:4]
//  MEM_READDATA  in   128  block data; word w occupies bits [32w+31:32w]
//  MEM_BUSYWAIT  in   1    memory is busy; data is valid when MEM_READ=1 and this is 0
//  HIT_COUNT     out  16   saturating count of hit lookups
//  MISS_COUNT    out  16   saturating count of misses
// BEHAVIOUR
//  Address split: offset = PC[3:2] (word select), index = PC[6:4], tag = PC[9:7].
//   PC[1:0] and PC[31:10] are ignored, so upper addresses alias.
//  Storage, per block: valid bit, TAG_BITS tag, 128-bit data. There is no dirty bit and
//   no write path.
//  hit = valid[index] && (tag_arr[index]==tag). This is combinational from PC.
//  INSTRUCTION = data[index] word[offset]. It is combinational and is don't-care while
//   BUSYWAIT=1.
//  FSM states are IDLE and FETCH.
//   IDLE, hit: BUSYWAIT=0 in the same cycle (zero-wait fetch). HIT_COUNT += 1 per
//    rising edge on which the state is IDLE, the lookup hits and RESET=0.
//   IDLE, miss: BUSYWAIT=1 combinationally. On the edge, latch miss_blk = PC[9:4],
//    go to FETCH, MISS_COUNT += 1.
//   FETCH: MEM_READ=1, MEM_ADDRESS=miss_blk, BUSYWAIT=1. The state holds while
//    MEM_BUSYWAIT=1.
//   FETCH with MEM_BUSYWAIT=0: on the edge, write data[miss_blk index] = MEM_READDATA,
//    set its tag, set valid=1, and go to IDLE.
//   The next IDLE cycle re-looks-up PC and hits, so BUSYWAIT drops that cycle.
//  Miss penalty: 1 detect cycle + N cycles in FETCH (N = memory latency) before the
//   hit cycle.
//  MEM_READ and MEM_ADDRESS are registered-state outputs. Outside FETCH: MEM_READ=0,
//   MEM_ADDRESS=0.
//  PC changing during FETCH: the refill still targets the latched miss_blk. Afterwards
//   the new PC is looked up normally.
//  Counters saturate at all-ones; they do not wrap.
//  Reset, taking priority over every event:
//   - all valid=0, state=IDLE, HIT_COUNT=0, MISS_COUNT=0, miss_blk=0;
//   - while RESET=1: BUSYWAIT=0, MEM_READ=0, MEM_ADDRESS=0, INSTRUCTION=0;
//   - the tag/data arrays are not cleared.
//  Reset mid-FETCH: the refill is abandoned. MEM_READ is 0 from the reset edge onward.
//   The block is not written, even if MEM_BUSYWAIT falls in the reset cycle.
//  A memory response arriving while in IDLE is ignored.
// TESTING
//  1. Reset then PC=0: BUSYWAIT=1 and MISS_COUNT=1; MEM_READ=1 with MEM_ADDRESS=0 for
//     the 4-cycle memory; then INSTRUCTION=word0 of block 0 with BUSYWAIT=0.
//  2. After test 1, PC=4,8,12 on consecutive cycles: BUSYWAIT=0 every cycle, words 1..3
//     are returned, HIT_COUNT increments by 3, no MEM_READ.
//  3. Conflict: PC=0x000 cached, then PC=0x080 (same index 0, tag 1): a miss with
//     MEM_ADDRESS=6'b001000. Then PC=0x000 misses again, so MISS_COUNT=3.
//  4. Fill all 8 indices (PC=0x00,0x10,...,0x70), then replay them: 8 misses then 8 hits,
//     each returning that block's word0.
//  5. Assert RESET for 1 cycle during FETCH while MEM_BUSYWAIT is falling: MEM_READ=0 and
//     counters=0 afterwards; the next PC=0 misses (valid was cleared).
//  6. Preload MISS_COUNT near saturation (or force 0xFFFE): two more misses leave it at
//     0xFFFF.

Source files
------------

// File: rtl/instr_cache.sv
// Direct-mapped, read-only instruction cache: zero-wait hits, one 128-bit block
// refill from the instruction memory on a miss, saturating hit/miss counters.
module instr_cache #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 3,
  parameter int CNT_BITS   = 16
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [31:0]                    PC,
  output logic [31:0]                    INSTRUCTION,
  output logic                           BUSYWAIT,
  output logic                           MEM_READ,
  output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
  input  logic [127:0]                   MEM_READDATA,
  input  logic                           MEM_BUSYWAIT,
  output logic [CNT_BITS-1:0]            HIT_COUNT,
  output logic [CNT_BITS-1:0]            MISS_COUNT
);
  localparam int BLK_BITS = TAG_BITS + INDEX_BITS;
  localparam int NUM_BLKS = 1 << INDEX_BITS;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                state_q, state_d;
  logic [NUM_BLKS-1:0]   valid_q;
  logic [TAG_BITS-1:0]   tag_arr  [NUM_BLKS];
  logic [127:0]          data_arr [NUM_BLKS];
  logic [BLK_BITS-1:0]   miss_blk_q;
  logic [CNT_BITS-1:0]   hit_cnt_q, miss_cnt_q;

  logic [1:0]            pc_off;
  logic [INDEX_BITS-1:0] pc_idx, fill_idx;
  logic [TAG_BITS-1:0]   pc_tag, fill_tag;
  logic [BLK_BITS-1:0]   pc_blk;
  logic                  hit, fill_done, hit_event, miss_event;
  logic [31:0]           blk_words [4];
  logic                  unused_pc;

  assign pc_off    = PC[3:2];
  assign pc_blk    = PC[4 +: BLK_BITS];
  assign pc_idx    = pc_blk[INDEX_BITS-1:0];
  assign pc_tag    = pc_blk[BLK_BITS-1:INDEX_BITS];
  assign fill_idx  = miss_blk_q[INDEX_BITS-1:0];
  assign fill_tag  = miss_blk_q[BLK_BITS-1:INDEX_BITS];
  assign unused_pc = ^{PC[31:4+BLK_BITS], PC[1:0]};

  assign hit        = valid_q[pc_idx] && (tag_arr[pc_idx] == pc_tag);
  assign fill_done  = (state_q == FETCH) && !MEM_BUSYWAIT;
  assign hit_event  = (state_q == IDLE) && hit;
  assign miss_event = (state_q == IDLE) && !hit;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      assign blk_words[gi] = data_arr[pc_idx][32*gi +: 32];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      miss_blk_q <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_event) miss_blk_q <= pc_blk;
      if (fill_done) valid_q[fill_idx] <= 1'b1;
      if (hit_event && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_BITS'(1);
      if (miss_event && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_BITS'(1);
    end
  end

  // Tag/data storage is deliberately left out of reset; valid_q alone gates it.
  always_ff @(posedge CLK) begin
    if (!RESET && fill_done) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= MEM_READDATA;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!hit) state_d = FETCH;
      FETCH: if (!MEM_BUSYWAIT) state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSYWAIT    = 1'b0;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = '0;
    INSTRUCTION = '0;
    if (!RESET) begin
      case (state_q)
        IDLE: begin
          BUSYWAIT    = !hit;
          INSTRUCTION = blk_words[pc_off];
        end
        FETCH: begin
          BUSYWAIT    = 1'b1;
          MEM_READ    = 1'b1;
          MEM_ADDRESS = miss_blk_q;
        end
      endcase
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: scoreboarded fetches against a 4-cycle memory
// model, plus a narrow-counter instance for saturation.
module tb_instr_cache;
  logic         CLK = 1'b0;
  logic         RESET, RESET_s;
  logic [31:0]  PC, PC_s;
  logic [31:0]  INSTRUCTION, INSTRUCTION_s;
  logic         BUSYWAIT, BUSYWAIT_s, MEM_READ, MEM_READ_s;
  logic [5:0]   MEM_ADDRESS, MEM_ADDRESS_s;
  logic [127:0] MEM_READDATA, MEM_READDATA_s;
  logic         MEM_BUSYWAIT, MEM_BUSYWAIT_s;
  logic [15:0]  HIT_COUNT, MISS_COUNT;
  logic [1:0]   HIT_COUNT_s, MISS_COUNT_s;

  int checks = 0;
  int errors = 0;
  int mem_cnt = 0;
  bit          m_valid [8];
  logic [2:0]  m_tag   [8];
  int          hit_exp, miss_exp;
  logic [31:0] exp_q [$];

  always #5 CLK = ~CLK;

  instr_cache dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
  );

  instr_cache #(.CNT_BITS(2)) dut_s (
    .CLK(CLK), .RESET(RESET_s), .PC(PC_s), .INSTRUCTION(INSTRUCTION_s), .BUSYWAIT(BUSYWAIT_s),
    .MEM_READ(MEM_READ_s), .MEM_ADDRESS(MEM_ADDRESS_s), .MEM_READDATA(MEM_READDATA_s),
    .MEM_BUSYWAIT(MEM_BUSYWAIT_s), .HIT_COUNT(HIT_COUNT_s), .MISS_COUNT(MISS_COUNT_s)
  );

  function automatic logic [31:0] mem_word(input logic [5:0] blk, input logic [1:0] w);
    return {8'hA5, 2'b00, blk, 6'h00, w, 8'h5A};
  endfunction

  function automatic logic [127:0] mem_block(input logic [5:0] blk);
    return {mem_word(blk, 2'd3), mem_word(blk, 2'd2), mem_word(blk, 2'd1), mem_word(blk, 2'd0)};
  endfunction

  // Memory model: fourth consecutive read cycle returns data.
  always @(posedge CLK) mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
  assign MEM_BUSYWAIT   = !(MEM_READ && mem_cnt == 3);
  assign MEM_READDATA   = mem_block(MEM_ADDRESS);
  assign MEM_BUSYWAIT_s = 1'b0;
  assign MEM_READDATA_s = mem_block(MEM_ADDRESS_s);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_counters();
    check("hit_count", {16'h0, HIT_COUNT}, hit_exp);
    check("miss_count", {16'h0, MISS_COUNT}, miss_exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    hit_exp  = 0;
    miss_exp = 0;
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("rst_busywait", {31'h0, BUSYWAIT}, 0);
    check("rst_mem_read", {31'h0, MEM_READ}, 0);
    check("rst_mem_addr", {26'h0, MEM_ADDRESS}, 0);
    check("rst_instr", INSTRUCTION, 0);
    @(negedge CLK);
    clear_model();
    $display("reset applied");
  endtask

  task automatic fetch(input logic [31:0] pc, input string tag);
    logic [5:0] blk;
    logic [2:0] idx;
    bit         is_hit;
    int         stalls;
    blk = pc[9:4];
    idx = pc[6:4];
    @(negedge CLK);
    check_counters();
    RESET = 1'b0;
    PC    = pc;
    is_hit = m_valid[idx] && (m_tag[idx] == pc[9:7]);
    exp_q.push_back(mem_word(blk, pc[3:2]));
    #1;
    stalls = 0;
    while (BUSYWAIT && stalls < 40) begin
      if (stalls > 0) begin
        check("fetch_mem_read", {31'h0, MEM_READ}, 1);
        check("fetch_mem_addr", {26'h0, MEM_ADDRESS}, {26'h0, blk});
      end else begin
        check("detect_mem_read", {31'h0, MEM_READ}, 0);
      end
      @(negedge CLK);
      #1;
      stalls++;
    end
    check("stall_cycles", stalls, is_hit ? 0 : 5);
    check(tag, INSTRUCTION, exp_q.pop_front());
    check("hit_mem_read", {31'h0, MEM_READ}, 0);
    if (!is_hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = pc[9:7];
      miss_exp++;
    end
    hit_exp++;
    $display("fetch %s pc=%h stalls=%0d instr=%h", tag, pc, stalls, INSTRUCTION);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    RESET = 1'b1; PC = '0;
    RESET_s = 1'b1; PC_s = '0;
    clear_model();
    reset_dut();

    fetch(32'h000, "t1_word0");
    fetch(32'h004, "t2_word1");
    fetch(32'h008, "t2_word2");
    fetch(32'h00C, "t2_word3");
    fetch(32'h080, "t3_conflict");
    fetch(32'h000, "t3_refetch");
    fetch(32'h406, "alias_word1");

    reset_dut();
    for (int i = 0; i < 8; i++) fetch(i * 16, "t4_fill");
    for (int i = 0; i < 8; i++) fetch(i * 16, "t4_replay");

    // Reset lands in the cycle where the memory answers: refill must be dropped.
    @(negedge CLK);
    check_counters();
    RESET = 1'b0;
    PC    = 32'h100;
    #1;
    n = 0;
    while (!(MEM_READ && !MEM_BUSYWAIT) && n < 40) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("t5_fall_cycle", n, 4);
    RESET = 1'b1;
    #1;
    check("t5_rst_mem_read", {31'h0, MEM_READ}, 0);
    check("t5_rst_busywait", {31'h0, BUSYWAIT}, 0);
    check("t5_rst_instr", INSTRUCTION, 0);
    @(negedge CLK);
    #1;
    check("t5_post_mem_read", {31'h0, MEM_READ}, 0);
    clear_model();
    check_counters();
    $display("reset during refill at pc=%h", 32'h100);
    fetch(32'h000, "t5_after_reset");
    fetch(32'h100, "t5_abandoned_blk");
    @(negedge CLK);
    check_counters();

    // Narrow counters: five conflict misses (each followed by a hit) saturate both.
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("sat_miss", {30'h0, MISS_COUNT_s}, (k < 3) ? k : 3);
      check("sat_hit", {30'h0, HIT_COUNT_s}, (k < 3) ? k : 3);
      RESET_s = 1'b0;
      PC_s    = (k % 2 == 1) ? 32'h080 : 32'h000;
      #1;
      n = 0;
      while (BUSYWAIT_s && n < 10) begin
        @(negedge CLK);
        #1;
        n++;
      end
      check("sat_stall", n, 2);
      check("sat_instr", INSTRUCTION_s, mem_word(PC_s[9:4], 2'd0));
      $display("sat fetch pc=%h stalls=%0d miss=%0d hit=%0d", PC_s, n, MISS_COUNT_s, HIT_COUNT_s);
    end
    @(negedge CLK);
    check("sat_miss_final", {30'h0, MISS_COUNT_s}, 3);
    check("sat_hit_final", {30'h0, HIT_COUNT_s}, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
